// File: rtl/dvp_pkg.sv
// Shared types and sizing helpers for the DVP frame transmitter.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_V_SYNC  = 3'd1,
        ST_V_BACK  = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_V_FRONT = 3'd4
    } dvp_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic int line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

    function automatic int col_width(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    function automatic int line_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dvp_frame_tx_if.sv
// RGB565 pixel stream with valid/ready handshake feeding the DVP transmitter.
interface dvp_frame_tx_if;

    dvp_pkg::rgb565_t pixel_data;
    logic             pixel_valid;
    logic             pixel_ready;

    modport master (output pixel_data, output pixel_valid, input pixel_ready);
    modport slave  (input pixel_data, input pixel_valid, output pixel_ready);

endinterface

// File: rtl/dvp_timing_counter.sv
// Column/line raster counters; col wraps every line, line wraps at the per-state last index.
module dvp_timing_counter #(
    parameter int LINE_LEN = 10,
    parameter int COL_W    = 4,
    parameter int LINE_W   = 2
) (
    input  logic              p_clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic [LINE_W-1:0] last_line_idx_i,
    output logic [COL_W-1:0]  col_d_o,
    output logic [LINE_W-1:0] line_d_o,
    output logic              last_col_o,
    output logic              last_line_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;

    assign last_col_o  = (col_q == COL_LAST);
    assign last_line_o = (line_q == last_line_idx_i);
    assign col_d_o     = col_d;
    assign line_d_o    = line_d;

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (clear_i) begin
            col_d  = '0;
            line_d = '0;
        end else if (last_col_o) begin
            col_d  = '0;
            line_d = last_line_o ? '0 : line_q + LINE_W'(1);
        end else begin
            col_d  = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/dvp_frame_tx.sv
// OV7670-style DVP stream generator: RGB565 pixels out as high/low bytes under vsync/href.
// All outputs are registered from the next raster position so they align with the state.
//   state    | meaning
//   IDLE     | outputs low, waiting for enable
//   V_SYNC   | vsync high for VSYNC_LINES lines
//   V_BACK   | blank lines before the first active line
//   ACTIVE   | href lines carrying pixel bytes, then H_BLANK
//   V_FRONT  | blank lines after the last active line; frame_end on the last cycle
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 288,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic           p_clock,
    input  logic           reset_n,
    input  logic           enable,
    dvp_frame_tx_if.slave  pix,
    output logic           vsync,
    output logic           href,
    output logic [7:0]     p_data,
    output logic           frame_end,
    output logic           underrun
);

    localparam int LINE_LEN = line_len(H_ACTIVE, H_BLANK);
    localparam int COL_W    = col_width(LINE_LEN);
    localparam int LINE_W   = line_width(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] HREF_COLS = COL_W'(2 * H_ACTIVE);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_V_SYNC  = 3'(ST_V_SYNC);
    localparam logic [2:0] S_V_BACK  = 3'(ST_V_BACK);
    localparam logic [2:0] S_ACTIVE  = 3'(ST_ACTIVE);
    localparam logic [2:0] S_V_FRONT = 3'(ST_V_FRONT);

    if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 ||
        VSYNC_LINES < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_bad_param
        $error("dvp_frame_tx: all timing parameters must be >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic [COL_W-1:0]  col_nxt;
    logic [LINE_W-1:0] line_nxt, last_line_idx;
    logic              last_col, last_line, end_of_state;

    rgb565_t           hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        p_data_q, p_data_d;
    logic              underrun_q, underrun_d;
    logic              vsync_q, href_q, frame_end_q;
    logic              act_d, fend_d, accept;

    dvp_timing_counter #(
        .LINE_LEN (LINE_LEN),
        .COL_W    (COL_W),
        .LINE_W   (LINE_W)
    ) u_timing (
        .p_clock         (p_clock),
        .reset_n         (reset_n),
        .clear_i         (state_q == S_IDLE),
        .last_line_idx_i (last_line_idx),
        .col_d_o         (col_nxt),
        .line_d_o        (line_nxt),
        .last_col_o      (last_col),
        .last_line_o     (last_line)
    );

    assign end_of_state = last_col && last_line;

    always_comb begin
        last_line_idx = '0;
        case (state_q)
            S_V_SYNC:  last_line_idx = LINE_W'(VSYNC_LINES - 1);
            S_V_BACK:  last_line_idx = LINE_W'(V_BACK - 1);
            S_ACTIVE:  last_line_idx = LINE_W'(V_ACTIVE - 1);
            S_V_FRONT: last_line_idx = LINE_W'(V_FRONT - 1);
            default:   last_line_idx = '0;
        endcase
    end

    // enable is only looked at in IDLE and on the very last cycle of a frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_V_SYNC;
            S_V_SYNC:  if (end_of_state) state_d = S_V_BACK;
            S_V_BACK:  if (end_of_state) state_d = S_ACTIVE;
            S_ACTIVE:  if (end_of_state) state_d = S_V_FRONT;
            S_V_FRONT: if (end_of_state) state_d = enable ? S_V_SYNC : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign act_d  = (state_d == S_ACTIVE) && (col_nxt < HREF_COLS);
    assign fend_d = (state_d == S_V_FRONT) && (col_nxt == COL_LAST) &&
                    (line_nxt == LINE_W'(V_FRONT - 1));

    assign pix.pixel_ready = ~hold_full_q;
    assign accept          = pix.pixel_valid && !hold_full_q;

    // Consume needs a full hold register and accept needs an empty one, so they never collide.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        lo_d        = lo_q;
        underrun_d  = underrun_q;
        p_data_d    = 8'h00;
        if (state_d == S_V_SYNC && state_q != S_V_SYNC) underrun_d = 1'b0;
        if (act_d) begin
            if (!col_nxt[0]) begin
                if (hold_full_q) begin
                    p_data_d    = hold_q[15:8];
                    lo_d        = hold_q[7:0];
                    hold_full_d = 1'b0;
                end else begin
                    p_data_d    = 8'h00;
                    lo_d        = 8'h00;
                    underrun_d  = 1'b1;
                end
            end else begin
                p_data_d = lo_q;
            end
        end
        if (accept) begin
            hold_d      = pix.pixel_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            lo_q        <= 8'h00;
            p_data_q    <= 8'h00;
            underrun_q  <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            lo_q        <= lo_d;
            p_data_q    <= p_data_d;
            underrun_q  <= underrun_d;
            vsync_q     <= (state_d == S_V_SYNC);
            href_q      <= act_d;
            frame_end_q <= fend_d;
        end
    end

    assign vsync     = vsync_q;
    assign href      = href_q;
    assign p_data    = p_data_q;
    assign frame_end = frame_end_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx: raster-position model plus accepted-pixel scoreboard.
module tb_dvp_frame_tx;
    import dvp_pkg::*;

    localparam int HA    = 4;
    localparam int HB    = 2;
    localparam int VA    = 2;
    localparam int VSL   = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LL    = 2 * HA + HB;
    localparam int FRAME = LL * (VSL + VB + VA + VF);
    localparam int ACT0  = LL * (VSL + VB) + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       vsync, href, frame_end, underrun;
    logic [7:0] p_data;

    dvp_frame_tx_if pix_if ();

    dvp_frame_tx #(
        .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
        .VSYNC_LINES (VSL), .V_BACK (VB), .V_FRONT (VF)
    ) dut (
        .p_clock   (clk),
        .reset_n   (rst_n),
        .enable    (en),
        .pix       (pix_if),
        .vsync     (vsync),
        .href      (href),
        .p_data    (p_data),
        .frame_end (frame_end),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          tf = 0;
    int          gidx = 0;
    logic [15:0] sb[$];
    logic [7:0]  lo_exp = 8'h00;
    logic        exp_und = 1'b0;
    logic        src_on = 1'b0;
    logic        src_auto = 1'b1;
    logic [15:0] cur_px = 16'h0000;
    logic [15:0] tbl[4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t tf=%0d)", tag, obs, expv, $time, tf);
        end
    endtask

    function automatic logic [15:0] gen_px();
        logic [15:0] r;
        if (gidx < 4) r = tbl[gidx];
        else          r = 16'($urandom);
        gidx++;
        return r;
    endfunction

    task automatic drive();
        pix_if.pixel_valid = src_on;
        pix_if.pixel_data  = rgb565_t'(cur_px);
    endtask

    task automatic cyc();
        logic        acc, en_s, h;
        logic [15:0] px, cur;
        logic [7:0]  exp_p;
        int          col;
        acc  = pix_if.pixel_valid && (sb.size() == 0);
        px   = pix_if.pixel_data;
        en_s = en;
        @(posedge clk);
        #1;
        if (tf == 0 || tf == FRAME) tf = en_s ? 1 : 0;
        else                        tf++;
        if (tf == 1) exp_und = 1'b0;
        h   = 1'b0;
        col = 0;
        if (tf >= ACT0 && tf < ACT0 + LL * VA) begin
            col = (tf - ACT0) % LL;
            h   = (col < 2 * HA);
        end
        exp_p = 8'h00;
        if (h) begin
            if (col % 2 == 0) begin
                if (sb.size() > 0) begin
                    cur    = sb.pop_front();
                    exp_p  = cur[15:8];
                    lo_exp = cur[7:0];
                end else begin
                    exp_und = 1'b1;
                    lo_exp  = 8'h00;
                end
            end else begin
                exp_p = lo_exp;
            end
        end
        if (acc) sb.push_back(px);
        chk("vsync",       16'(vsync),              16'(tf >= 1 && tf <= LL * VSL));
        chk("href",        16'(href),               16'(h));
        chk("p_data",      16'(p_data),             16'(exp_p));
        chk("frame_end",   16'(frame_end),          16'(tf == FRAME));
        chk("underrun",    16'(underrun),           16'(exp_und));
        chk("pixel_ready", 16'(pix_if.pixel_ready), 16'(sb.size() == 0));
        if (acc) begin
            if (src_auto) cur_px = gen_px();
            else          src_on = 1'b0;
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (tf != target && n < 200) begin
            cyc();
            n++;
        end
        tests++;
        assert (tf == target) else begin
            fails++;
            $error("FAIL run_until: frame position %0d expected %0d", tf, target);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vsync"},     16'(vsync),              16'h0);
        chk({tag, "_href"},      16'(href),               16'h0);
        chk({tag, "_p_data"},    16'(p_data),             16'h0);
        chk({tag, "_frame_end"}, 16'(frame_end),          16'h0);
        chk({tag, "_underrun"},  16'(underrun),           16'h0);
        chk({tag, "_ready"},     16'(pix_if.pixel_ready), 16'h1);
    endtask

    initial begin
        drive();
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            en                 = 1'($urandom);
            pix_if.pixel_valid = 1'($urandom);
            pix_if.pixel_data  = rgb565_t'(16'($urandom));
            #1;
            chk_all_zero("reset");
        end
        en = 1'b0;
        drive();
        rst_n = 1'b1;
        run(3);

        // Frame 1: continuous source, known first four pixels
        gidx     = 0;
        src_auto = 1'b1;
        cur_px   = gen_px();
        src_on   = 1'b1;
        drive();
        en = 1'b1;
        run(FRAME);

        // Frame 2: source stops after last refill of line 0 -> line 1 underruns
        run_until(ACT0 + 6);
        src_on = 1'b0;
        drive();

        // Frame 3: single prefetch during vsync, second pixel must wait for hold to drain
        run_until(3);
        src_auto = 1'b0;
        cur_px   = 16'h1234;
        src_on   = 1'b1;
        drive();
        cyc();
        cur_px = 16'h5678;
        src_on = 1'b1;
        drive();
        run_until(ACT0 + LL * VA - 1);

        // Frame 4: full supply, enable dropped during active line 1
        src_auto = 1'b1;
        cur_px   = gen_px();
        src_on   = 1'b1;
        drive();
        run_until(ACT0 + LL + 1);
        en = 1'b0;
        run_until(FRAME);
        run(15);

        // Reset in the middle of an active line
        en = 1'b1;
        run_until(ACT0 + 3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tf      = 0;
        sb.delete();
        exp_und = 1'b0;
        lo_exp  = 8'h00;
        @(posedge clk);
        #1;
        chk_all_zero("midreset_hold");
        rst_n = 1'b1;
        run(FRAME + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
